// File: rtl/demux_collect_pkg.sv
// demux_collect_pkg: shared lane constants, lane index type and round-robin helper
package demux_collect_pkg;
  localparam int NLANES = 8;
  localparam int SEL_W = 3;
  typedef logic [SEL_W-1:0] lane_t;
  function automatic lane_t rr_next(lane_t l);
    return l + lane_t'(1);
  endfunction
endpackage

// File: rtl/collect_lane.sv
// collect_lane: one lane's shift register, bit count, holding register and sticky overflow
// DEMUX_COLLECT_MSB_FIRST_EN selects that the first bit lands in the word MSB
module collect_lane #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             din,
  input  logic             rd,
  input  logic             ovf_clr,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0] cnt;
  logic done, load;
`ifdef DEMUX_COLLECT_MSB_FIRST_EN
  assign sr_nxt = {sr[WIDTH-2:0], din};
`else
  assign sr_nxt = {din, sr[WIDTH-1:1]};
`endif
  assign done = shift_en && cnt == CW'(WIDTH-1);
  // a read in the same cycle frees the holding register for the new word
  assign load = done && (!hold_full || rd);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      ovf <= 1'b0;
    end else begin
      if (shift_en) begin
        sr <= sr_nxt;
        cnt <= done ? '0 : cnt + CW'(1);
      end
      if (load) hold_data <= sr_nxt;
      hold_full <= load || (hold_full && !rd);
      ovf <= (done && !load) || (ovf && !ovf_clr);
    end
endmodule

// File: rtl/demux_word_collector.sv
// demux_word_collector: assembles demux lane bits into words, round-robin drained over valid/ready
// DEMUX_COLLECT_MSB_FIRST_EN selects that the first bit lands in the word MSB
module demux_word_collector
  import demux_collect_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic [SEL_W-1:0]  sel,
  input  logic [NLANES-1:0] demux_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [SEL_W-1:0]  word_lane,
  output logic [WIDTH-1:0]  word_data,
  output logic [NLANES-1:0] ovf,
  input  logic              ovf_clr
);
  logic [NLANES-1:0] hf, rd;
  logic [WIDTH-1:0] hd [NLANES];
  lane_t rr, lk_lane, scan;
  logic lk, xfer;
  always_comb begin
    scan = rr;
    for (int i = NLANES-1; i >= 0; i--)
      if (hf[rr + lane_t'(i)]) scan = rr + lane_t'(i);
  end
  // a stalled offer stays pinned to its lane until the handshake
  assign word_lane = lk ? lk_lane : scan;
  assign word_valid = |hf;
  assign word_data = hd[word_lane];
  assign xfer = word_valid && word_ready;
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    assign rd[k] = xfer && word_lane == lane_t'(k);
    collect_lane #(.WIDTH(WIDTH)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .shift_en(bit_valid && sel == lane_t'(k)),
      .din(demux_out[k]),
      .rd(rd[k]),
      .ovf_clr(ovf_clr),
      .hold_full(hf[k]),
      .hold_data(hd[k]),
      .ovf(ovf[k])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr <= '0;
      lk <= 1'b0;
      lk_lane <= '0;
    end else begin
      lk <= word_valid && !word_ready;
      lk_lane <= word_lane;
      if (xfer) rr <= rr_next(word_lane);
    end
endmodule

// File: doc/demux_word_collector.md
# demux_word_collector

Downstream stage for the 1:8 bit demultiplexer: takes its 8-lane output plus the select that steered it and assembles each lane's serial bits into WIDTH-bit words. Every lane is double-buffered: a shift register plus a holding register. Completed words leave through one valid/ready port under a round-robin arbiter, so a single consumer can drain all eight lanes.

## Interface
- WIDTH, 8, bits per assembled word (2..32)
- NLANES, 8, lane count; fixed to match the 3-bit demux select
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bit_valid  in  1  demux output and select are meaningful this cycle
- sel  in  3  lane that the demux steered the input bit to
- demux_out  in  8  demux output vector; sampled bit is demux_out[sel]
- word_valid  out  1  a completed word is offered
- word_ready  in  1  consumer accepts the offered word
- word_lane  out  3  lane of the offered word
- word_data  out  WIDTH  offered word
- ovf  out  8  sticky per-lane overflow flags
- ovf_clr  in  1  one-cycle pulse that clears all ovf bits

## Operation
- Bit accept: on a clk edge with bit_valid=1, demux_out[sel] shifts into lane sel's shift register and that lane's count increments. Other lanes are untouched. Bits are never back-pressured.
- Word complete: the edge that brings a lane's count to WIDTH moves the assembled word into the lane's holding register, sets hold_full, and resets the count to 0. The shift register is free for new bits on the next cycle.
- Overflow: if the lane's hold_full is set at completion and the holding word is not being read that same cycle, the new word is discarded and ovf[lane] is set. The holding register keeps the old word.
- Simultaneous read and complete on the same lane: the read frees the holding register and the new word is loaded in the same edge. No overflow.
- Arbiter: round-robin pointer rr (3 bits). The grant is the first lane with hold_full, searching upward from rr with wrap 7→0.
  - On a transfer (word_valid & word_ready), rr becomes granted lane + 1 (mod 8) and that lane's hold_full clears.
- Grant lock: while word_valid=1 and word_ready=0, word_lane and word_data hold stable, even if a higher-priority lane fills.
- ovf_clr: clears all ovf bits. If an overflow event occurs in the same cycle, the set wins for that lane.
- Reset mid-word: partial shift contents, counts, holding registers, rr and ovf are all discarded.

## Timing
- Reset values: word_valid=0, word_lane=0, word_data=0, ovf=8'h00. Internally rr=0, all counts 0, all hold_full 0.
- Latency: the edge that accepts bit WIDTH of a word sets hold_full. word_valid is high in the following cycle if that lane wins arbitration.
- word_valid is a registered-state function (hold_full plus lock) and has no combinational path from bit_valid.
- word_ready may combinationally affect only internal next-state, never word_valid, word_lane or word_data in the same cycle.
- Throughput: one word per cycle at the output when word_ready=1 and words are pending.

## Configuration
- DEMUX_COLLECT_MSB_FIRST_EN
  - Defined: bits shift in at the LSB, so the first received bit ends up at word_data[WIDTH-1].
  - Undefined (default): bits shift in at the MSB, so the first received bit ends up at word_data[0].

## Structure
- Package demux_collect_pkg holds:
  - NLANES=8 and SEL_W=3
  - lane index typedef lane_t (3 bits)
  - helper function rr_next(lane_t) returning (lane+1) mod 8
- Sub-module collect_lane is instantiated NLANES times. Each instance contains:
  - shift register, count, holding register, hold_full and ovf bit
  - ports: shift enable, data bit, read strobe, ovf_clr
- Arbiter, grant lock and output mux live in the top level.

## Test plan
- Reset then 8 bits 1,0,1,1,0,0,1,0 on sel=3 with word_ready=1. Expect:
  - LSB-first build: word_valid one cycle later, word_lane=3, word_data=8'h4D
  - with DEMUX_COLLECT_MSB_FIRST_EN: word_data=8'hB2
- Fill lanes 0, 5 and 7 simultaneously (interleaved bits), word_ready=1 → words appear in order 0, 5, 7. Refill lane 0 and lane 5 → order is 0, 5 (rr wrapped past 7).
- Hold word_ready=0 with lane 2 pending, then complete lane 1 → word_lane stays 2 and word_data is unchanged until the handshake; lane 1 follows.
- Complete two words on lane 6 with word_ready=0 → ovf=8'h40, first word kept. Pulse ovf_clr → ovf=8'h00.
- Lane 4 holding full, word_ready=1 on the same edge its next word completes → both words delivered in turn, ovf[4]=0.
- Assert rst_n=0 after 5 bits on lane 1 → after release, 8 new bits 8'hFF produce word_data=8'hFF with no stale bits.
